// File: rtl/fft_pkg.sv
// Shared FFT definitions: butterfly mode encodings, default transform length and a log2 helper.
package fft_pkg;

    localparam int unsigned FFT_LEN = 32;

    typedef enum logic [1:0] {
        BF_IDLE    = 2'b00,
        BF_FIRST   = 2'b01,
        BF_SECOND  = 2'b10,
        BF_WAITING = 2'b11
    } bf_state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdf_r2_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF FFT stage: butterfly mode, twiddle index,
// delay-line enable and frame-aligned output valid/start-of-frame.
module sdf_r2_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned N_FFT = FFT_LEN,
    parameter int unsigned HALF  = 16,
    parameter int unsigned CW    = (HALF > 1) ? log2(HALF) : 1,
    parameter int unsigned WW    = log2(N_FFT / 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [1:0]    bf_state,
    output logic [WW-1:0] wn_idx,
    output logic          sr_en,
    output logic          out_valid,
    output logic          out_sof,
    output logic          err
);

    localparam int unsigned   STRIDE   = N_FFT / (2 * HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    bf_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nf_q, nf_d;
    logic          err_q, err_d;
    logic [WW-1:0] wn_idx_q, wn_idx_d;
    logic          sr_en_q, sr_en_d;
    logic          out_valid_q, out_valid_d;
    logic          out_sof_q, out_sof_d;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nf_d        = nf_q;
        err_d       = 1'b0;

        case (state_q)
            BF_IDLE: begin
                nf_d = 1'b0;
                if (in_valid) begin
                    state_d = BF_WAITING;
                    cnt_d   = '0;
                end
            end
            BF_WAITING: begin
                if (!in_valid) begin
                    state_d = BF_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_last) begin
                    state_d = BF_FIRST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BF_FIRST: begin
                if (cnt_last) begin
                    state_d = BF_SECOND;
                    cnt_d   = '0;
                    nf_d    = in_valid;
                end else if (!in_valid) begin
                    state_d = BF_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BF_SECOND: begin
                // The drain always runs to completion; only the overlapping frame can abort.
                if (cnt_last) begin
                    cnt_d = '0;
                    nf_d  = 1'b0;
                    if (nf_q && in_valid) begin
                        state_d = BF_FIRST;
                    end else if (nf_q) begin
                        state_d = BF_IDLE;
                        err_d   = 1'b1;
                    end else if (in_valid) begin
                        state_d = BF_WAITING;
                    end else begin
                        state_d = BF_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (nf_q && !in_valid) begin
                        err_d = 1'b1;
                        nf_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = BF_IDLE;
                cnt_d   = '0;
                nf_d    = 1'b0;
            end
        endcase

        sr_en_d     = (state_d != BF_IDLE);
        out_valid_d = (state_d == BF_FIRST) || (state_d == BF_SECOND);
        out_sof_d   = (state_d == BF_FIRST) && (cnt_d == '0);
        wn_idx_d    = (state_d == BF_SECOND) ? WW'(32'(cnt_d) * STRIDE) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BF_IDLE;
            cnt_q       <= '0;
            nf_q        <= 1'b0;
            err_q       <= 1'b0;
            wn_idx_q    <= '0;
            sr_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nf_q        <= nf_d;
            err_q       <= err_d;
            wn_idx_q    <= wn_idx_d;
            sr_en_q     <= sr_en_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
        end
    end

    // During SECOND without an overlapping frame, only the final drain slot may start a new one.
    assign in_ready  = !rst && ((state_q != BF_SECOND) || nf_q || cnt_last);
    assign bf_state  = state_q;
    assign wn_idx    = wn_idx_q;
    assign sr_en     = sr_en_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sdf_r2_stage_ctrl.sv
// Directed scoreboard bench for sdf_r2_stage_ctrl with HALF=16 and HALF=8 instances.
module tb_sdf_r2_stage_ctrl;
    import fft_pkg::*;

    typedef struct {
        logic       r;
        logic       v;
        logic       rdy;
        logic [1:0] st;
        logic [3:0] wn;
        logic       ov;
        logic       sof;
        logic       er;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v16 = 1'b0;
    logic       v8  = 1'b0;
    logic       rdy16, rdy8, sr16, sr8, ov16, ov8, sof16, sof8, er16, er8;
    logic [1:0] bf16, bf8;
    logic [3:0] wn16, wn8;

    step_t plan[$];
    step_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    n_step = 0;

    always #5 clk = ~clk;

    sdf_r2_stage_ctrl #(.N_FFT(32), .HALF(16), .CW(4), .WW(4)) u_h16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .bf_state(bf16),
        .wn_idx(wn16), .sr_en(sr16), .out_valid(ov16), .out_sof(sof16), .err(er16)
    );

    sdf_r2_stage_ctrl #(.N_FFT(32), .HALF(8), .CW(3), .WW(4)) u_h8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .bf_state(bf8),
        .wn_idx(wn8), .sr_en(sr8), .out_valid(ov8), .out_sof(sof8), .err(er8)
    );

    task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, idx, obs, expv);
        end
    endtask

    // n consecutive cycles driving v, expecting state st after each edge.
    task automatic seg(input int n, input logic v, input logic rdy0, input logic rdyn,
                       input logic [1:0] st, input int wn0, input int wstep,
                       input logic sof0, input logic er0);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s.r   = 1'b0;
            s.v   = v;
            s.rdy = (k == 0) ? rdy0 : rdyn;
            s.st  = st;
            s.wn  = 4'(wn0 + k * wstep);
            s.ov  = (st == BF_FIRST) || (st == BF_SECOND);
            s.sof = (k == 0) && sof0;
            s.er  = (k == 0) && er0;
            plan.push_back(s);
        end
    endtask

    task automatic rst_step(input logic v);
        step_t s;
        s = '{r: 1'b1, v: v, rdy: 1'b0, st: BF_IDLE, wn: 4'd0, ov: 1'b0, sof: 1'b0, er: 1'b0};
        plan.push_back(s);
    endtask

    task automatic full_frame_16();
        seg(16, 1'b1, 1'b1, 1'b1, BF_WAITING, 0, 0, 1'b0, 1'b0);
        seg(16, 1'b1, 1'b1, 1'b1, BF_FIRST,   0, 0, 1'b1, 1'b0);
    endtask

    task automatic run(input bit sel);
        step_t p, e;
        while (plan.size() > 0) begin
            p = plan.pop_front();
            @(negedge clk);
            rst = p.r;
            v16 = sel ? 1'b0 : p.v;
            v8  = sel ? p.v : 1'b0;
            #1;
            chk("in_ready", n_step, 8'(sel ? rdy8 : rdy16), 8'(p.rdy));
            exp_q.push_back(p);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("bf_state",  n_step, 8'(sel ? bf8  : bf16),  8'(e.st));
            chk("wn_idx",    n_step, 8'(sel ? wn8  : wn16),  8'(e.wn));
            chk("sr_en",     n_step, 8'(sel ? sr8  : sr16),  8'(e.st != BF_IDLE));
            chk("out_valid", n_step, 8'(sel ? ov8  : ov16),  8'(e.ov));
            chk("out_sof",   n_step, 8'(sel ? sof8 : sof16), 8'(e.sof));
            chk("err",       n_step, 8'(sel ? er8  : er16),  8'(e.er));
            n_step++;
        end
    endtask

    initial begin
        // Reset state, then idle.
        rst_step(1'b0);
        rst_step(1'b0);
        seg(2, 1'b0, 1'b1, 1'b1, BF_IDLE, 0, 0, 1'b0, 1'b0);

        // Single frame.
        full_frame_16();
        seg(16, 1'b0, 1'b1, 1'b0, BF_SECOND, 0, 1, 1'b0, 1'b0);
        seg(3,  1'b0, 1'b1, 1'b1, BF_IDLE,   0, 0, 1'b0, 1'b0);

        // Back-to-back frames.
        full_frame_16();
        seg(16, 1'b1, 1'b1, 1'b1, BF_SECOND, 0, 1, 1'b0, 1'b0);
        seg(16, 1'b1, 1'b1, 1'b1, BF_FIRST,  0, 0, 1'b1, 1'b0);
        seg(16, 1'b0, 1'b1, 1'b0, BF_SECOND, 0, 1, 1'b0, 1'b0);
        seg(2,  1'b0, 1'b1, 1'b1, BF_IDLE,   0, 0, 1'b0, 1'b0);

        // Abort in WAITING at the 6th sample.
        seg(5, 1'b1, 1'b1, 1'b1, BF_WAITING, 0, 0, 1'b0, 1'b0);
        seg(1, 1'b0, 1'b1, 1'b1, BF_IDLE,    0, 0, 1'b0, 1'b1);
        seg(1, 1'b0, 1'b1, 1'b1, BF_IDLE,    0, 0, 1'b0, 1'b0);

        // Overlapping frame drops at cnt=5; drain still completes.
        full_frame_16();
        seg(6, 1'b1, 1'b1, 1'b1, BF_SECOND, 0, 1, 1'b0, 1'b0);
        seg(1, 1'b0, 1'b1, 1'b1, BF_SECOND, 6, 1, 1'b0, 1'b1);
        seg(9, 1'b0, 1'b0, 1'b0, BF_SECOND, 7, 1, 1'b0, 1'b0);
        seg(2, 1'b0, 1'b1, 1'b1, BF_IDLE,   0, 0, 1'b0, 1'b0);

        // Misaligned start pulse ignored at cnt=3; accepted at cnt=15.
        full_frame_16();
        seg(4,  1'b0, 1'b1, 1'b0, BF_SECOND,  0, 1, 1'b0, 1'b0);
        seg(1,  1'b1, 1'b0, 1'b0, BF_SECOND,  4, 1, 1'b0, 1'b0);
        seg(11, 1'b0, 1'b0, 1'b0, BF_SECOND,  5, 1, 1'b0, 1'b0);
        seg(1,  1'b1, 1'b1, 1'b1, BF_WAITING, 0, 0, 1'b0, 1'b0);
        seg(1,  1'b0, 1'b1, 1'b1, BF_IDLE,    0, 0, 1'b0, 1'b1);
        seg(1,  1'b0, 1'b1, 1'b1, BF_IDLE,    0, 0, 1'b0, 1'b0);
        run(1'b0);

        // HALF=8 stage: twiddle stride 2, then reset mid-FIRST.
        seg(8, 1'b1, 1'b1, 1'b1, BF_WAITING, 0, 0, 1'b0, 1'b0);
        seg(8, 1'b1, 1'b1, 1'b1, BF_FIRST,   0, 0, 1'b1, 1'b0);
        seg(8, 1'b0, 1'b1, 1'b0, BF_SECOND,  0, 2, 1'b0, 1'b0);
        seg(2, 1'b0, 1'b1, 1'b1, BF_IDLE,    0, 0, 1'b0, 1'b0);
        seg(8, 1'b1, 1'b1, 1'b1, BF_WAITING, 0, 0, 1'b0, 1'b0);
        seg(3, 1'b1, 1'b1, 1'b1, BF_FIRST,   0, 0, 1'b1, 1'b0);
        rst_step(1'b1);
        seg(2, 1'b0, 1'b1, 1'b1, BF_IDLE,    0, 0, 1'b0, 1'b0);
        run(1'b1);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
